// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x3 active-low key matrix (rows driven, columns sensed) and presents
// a debounced one-hot digit vector plus separate '*' and '#' flags to the
// keypad encoder.
//
// Each row is strobed for SCAN_DIV cycles. On the last dwell cycle, that row's
// columns are captured. At the row3 capture a frame code is formed: the key's
// index if exactly one contact closed, otherwise NONE. The outputs only follow
// a frame code once it has been seen on DEBOUNCE consecutive frames.
//
// Parameters:
//   SCAN_DIV  - cycles each row is driven (>= 4)
//   DEBOUNCE  - consecutive identical frames needed before outputs update (1..15)
//
// Ports:
//   clk          in   1  clock, rising edge
//   clrn         in   1  asynchronous active-low reset
//   col_n        in   3  matrix columns, active low, col_n[0] = left column
//   row_n        out  4  row strobes, active-low one-hot, row_n[0] = top row
//   keypad       out 10  debounced one-hot digit (key d -> bit 10-d, key 0 -> bit 0)
//   key_star     out  1  debounced '*' held
//   key_hash     out  1  debounced '#' held
//   key_pressed  out  1  one-cycle pulse when a new non-empty stable code is accepted
//
// Build option:
//   KEYPAD_SYNC_EN - when defined, col_n passes through a two-flop synchronizer
//                    before sampling; when undefined, col_n is sampled directly.
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV = 100,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [9:0] keypad,
    output logic       key_star,
    output logic       key_hash,
    output logic       key_pressed
);

    localparam int             DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]     DEB_MAX    = 4'(DEBOUNCE);
    localparam logic [3:0]     CODE_NONE  = 4'hF;

    // Debounce FSM: IDLE while the stable code is NONE, TRACK while a key is stable.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    // ------------------------------------------------------------------
    // Column input conditioning
    // ------------------------------------------------------------------
    logic [2:0] col_s;

`ifdef KEYPAD_SYNC_EN
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;

    // Reset to "all released" so the first samples after reset see no contact.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= col_n;
            sync2_q <= sync1_q;
        end
    end

    assign col_s = sync2_q;
`else
    assign col_s = col_n;
`endif

    // Active-high contact view of the currently driven row.
    logic [2:0] contacts_live;
    assign contacts_live = ~col_s;

    // ------------------------------------------------------------------
    // Row sequencer
    // ------------------------------------------------------------------
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    row_n_q, row_n_d;
    logic          last_dwell;
    logic          frame_end;

    assign last_dwell = (dwell_q == DWELL_LAST);
    assign frame_end  = last_dwell && (row_idx_q == 2'd3);

    always_comb begin
        dwell_d   = dwell_q + {{(DW-1){1'b0}}, 1'b1};
        row_idx_d = row_idx_q;
        row_n_d   = row_n_q;
        if (last_dwell) begin
            dwell_d   = '0;
            row_idx_d = row_idx_q + 2'd1;
            row_n_d   = {row_n_q[2:0], row_n_q[3]};
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dwell_q   <= '0;
            row_idx_q <= 2'd0;
            row_n_q   <= 4'b1110;
        end else begin
            dwell_q   <= dwell_d;
            row_idx_q <= row_idx_d;
            row_n_q   <= row_n_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-row column samples. Row3 is never stored: the frame code uses
    // the live row3 contacts on the same edge they would be captured.
    // ------------------------------------------------------------------
    logic [8:0] samp_flat;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_samp
            logic [2:0] samp_q;

            always_ff @(posedge clk or negedge clrn) begin
                if (!clrn) begin
                    samp_q <= 3'b000;
                end else if (last_dwell && (row_idx_q == 2'(gi))) begin
                    samp_q <= contacts_live;
                end
            end

            assign samp_flat[gi*3 +: 3] = samp_q;
        end
    endgenerate

    // Bit index = row*3 + column; bit 0 is key '1', bit 11 is key '#'.
    logic [11:0] frame_bits;
    assign frame_bits = {contacts_live, samp_flat};

    // ------------------------------------------------------------------
    // Frame code: index of the single closed contact, else NONE
    // (covers both the empty matrix and ghosting / multi-press).
    // ------------------------------------------------------------------
    logic [3:0] n_set;
    logic [3:0] last_idx;
    logic [3:0] frame_code;

    always_comb begin
        n_set    = 4'd0;
        last_idx = CODE_NONE;
        for (int i = 0; i < 12; i++) begin
            if (frame_bits[i]) begin
                n_set    = n_set + 4'd1;
                last_idx = 4'(i);
            end
        end
        frame_code = (n_set == 4'd1) ? last_idx : CODE_NONE;
    end

    // Map a frame code onto the encoder-facing output format.
    logic [9:0] dec_keypad;
    logic       dec_star;
    logic       dec_hash;

    always_comb begin
        dec_keypad = 10'b0;
        dec_star   = 1'b0;
        dec_hash   = 1'b0;
        case (frame_code)
            4'd0:    dec_keypad = 10'b1000000000;  // '1'
            4'd1:    dec_keypad = 10'b0100000000;  // '2'
            4'd2:    dec_keypad = 10'b0010000000;  // '3'
            4'd3:    dec_keypad = 10'b0001000000;  // '4'
            4'd4:    dec_keypad = 10'b0000100000;  // '5'
            4'd5:    dec_keypad = 10'b0000010000;  // '6'
            4'd6:    dec_keypad = 10'b0000001000;  // '7'
            4'd7:    dec_keypad = 10'b0000000100;  // '8'
            4'd8:    dec_keypad = 10'b0000000010;  // '9'
            4'd9:    dec_star   = 1'b1;            // '*'
            4'd10:   dec_keypad = 10'b0000000001;  // '0'
            4'd11:   dec_hash   = 1'b1;            // '#'
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] stable_q, stable_d;
    logic [0:0] state_q, state_d;
    logic [9:0] keypad_q, keypad_d;
    logic       star_q, star_d;
    logic       hash_q, hash_d;
    logic       pressed_q, pressed_d;

    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        stable_d  = stable_q;
        state_d   = state_q;
        keypad_d  = keypad_q;
        star_d    = star_q;
        hash_d    = hash_q;
        pressed_d = 1'b0;

        if (frame_end) begin
            if (frame_code == cand_q) begin
                cnt_d = (cnt_q >= DEB_MAX) ? DEB_MAX : cnt_q + 4'd1;
            end else begin
                cand_d = frame_code;
                cnt_d  = 4'd1;
            end

            // Once saturated, the outputs are simply reloaded each frame with
            // the same values; only a change to a real key raises the pulse.
            if (cnt_d == DEB_MAX) begin
                stable_d  = frame_code;
                keypad_d  = dec_keypad;
                star_d    = dec_star;
                hash_d    = dec_hash;
                pressed_d = (frame_code != CODE_NONE) &&
                            ((state_q == ST_IDLE) || (frame_code != stable_q));
                state_d   = (frame_code == CODE_NONE) ? ST_IDLE : ST_TRACK;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cand_q    <= CODE_NONE;
            cnt_q     <= 4'd0;
            stable_q  <= CODE_NONE;
            state_q   <= ST_IDLE;
            keypad_q  <= 10'b0;
            star_q    <= 1'b0;
            hash_q    <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            state_q   <= state_d;
            keypad_q  <= keypad_d;
            star_q    <= star_d;
            hash_q    <= hash_d;
            pressed_q <= pressed_d;
        end
    end

    assign row_n       = row_n_q;
    assign keypad      = keypad_q;
    assign key_star    = star_q;
    assign key_hash    = hash_q;
    assign key_pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int S     = 4;
    localparam int D     = 2;
    localparam int FRAME = 4 * S;
    localparam int NONE  = 15;

    logic       clk  = 1'b0;
    logic       clrn = 1'b0;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [9:0] keypad;
    logic       key_star;
    logic       key_hash;
    logic       key_pressed;

    // Set of held keys, bit = row*3 + column (bit 0 = '1', bit 11 = '#').
    logic [11:0] mask = '0;

    keypad_scanner #(.SCAN_DIV(S), .DEBOUNCE(D)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .col_n       (col_n),
        .row_n       (row_n),
        .keypad      (keypad),
        .key_star    (key_star),
        .key_hash    (key_hash),
        .key_pressed (key_pressed)
    );

    always #5 clk = ~clk;

    // Physical matrix: a held key pulls its column low while its row is driven.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            if (row_n[r] == 1'b0) begin
                for (int c = 0; c < 3; c++) begin
                    if (mask[r*3 + c]) col_n[c] = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic [9:0] kp;
        logic       st;
        logic       hs;
        logic       pulse;
    } exp_t;

    exp_t exp_frame_q[$];
    exp_t exp_pulse_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    string labels = "123456789*0#";
    int    m_last;
    int    m_run;
    int    m_stable;

    function automatic exp_t outputs_of(input int code, input logic pulse);
        exp_t e;
        byte  ch;
        int   d;
        e.kp = '0; e.st = 1'b0; e.hs = 1'b0; e.pulse = pulse;
        if (code != NONE) begin
            ch = labels[code];
            if (ch == "*")      e.st = 1'b1;
            else if (ch == "#") e.hs = 1'b1;
            else begin
                d = int'(ch) - int'("0");
                e.kp = (d == 0) ? 10'd1 : (10'd1 << (10 - d));
            end
        end
        return e;
    endfunction

    function automatic int code_of(input logic [11:0] m);
        int code = NONE;
        if ($countones(m) == 1) begin
            for (int i = 0; i < 12; i++) if (m[i]) code = i;
        end
        return code;
    endfunction

    task automatic model_reset();
        m_last   = -1;
        m_run    = 0;
        m_stable = NONE;
        exp_frame_q.delete();
        exp_pulse_q.delete();
    endtask

    task automatic model_frame(input logic [11:0] m);
        int   code;
        logic pulse;
        exp_t e;
        code = code_of(m);
        if (code == m_last) m_run++;
        else begin
            m_last = code;
            m_run  = 1;
        end
        pulse = 1'b0;
        if (m_run >= D) begin
            pulse    = (code != NONE) && (code != m_stable);
            m_stable = code;
        end
        e = outputs_of(m_stable, pulse);
        exp_frame_q.push_back(e);
        if (pulse) exp_pulse_q.push_back(e);
    endtask

    // ---------------- monitors ----------------
    int cyc;
    always @(posedge clk or negedge clrn) begin
        if (!clrn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        logic [3:0] rexp;
        exp_t       e;
        if (!clrn) begin
            chk("reset_row_n", row_n, 4'b1110);
            chk("reset_outputs", {keypad, key_star, key_hash, key_pressed}, 13'd0);
        end else begin
            rexp = ~(4'b0001 << ((cyc / S) % 4));
            chk("row_n", row_n, rexp);
            if (cyc > 0 && (cyc % FRAME) == 0) begin
                if (exp_frame_q.size() == 0) begin
                    chk("frame_queue_nonempty", 0, 1);
                end else begin
                    e = exp_frame_q.pop_front();
                    chk("frame_keypad", keypad, e.kp);
                    chk("frame_key_star", key_star, e.st);
                    chk("frame_key_hash", key_hash, e.hs);
                    chk("frame_key_pressed", key_pressed, e.pulse);
                end
            end else begin
                chk("no_pulse_midframe", key_pressed, 1'b0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (clrn && key_pressed) begin
            if (exp_pulse_q.size() == 0) begin
                chk("pulse_expected", 0, 1);
            end else begin
                e = exp_pulse_q.pop_front();
                chk("pulse_keypad", keypad, e.kp);
                chk("pulse_star_hash", {key_star, key_hash}, {e.st, e.hs});
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge aligned with a frame start.
    task automatic frame(input logic [11:0] m);
        mask = m;
        model_frame(m);
        repeat (FRAME) @(negedge clk);
    endtask

    task automatic frames(input logic [11:0] m, input int n);
        for (int i = 0; i < n; i++) frame(m);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        #2 clrn = 1'b0;
        #1;
        chk("async_reset_outputs", {keypad, key_star, key_hash, key_pressed}, 13'd0);
        chk("async_reset_row_n", row_n, 4'b1110);
        model_reset();
        repeat (hold) @(negedge clk);
        #2 clrn = 1'b1;
    endtask

    function automatic logic [11:0] key_bit(input int idx);
        logic [11:0] b;
        b = 12'd1 << idx;
        return b;
    endfunction

    initial begin
        int kind;
        int hold;
        logic [11:0] m;

        model_reset();
        clrn = 1'b0;
        mask = '0;
        repeat (3) @(negedge clk);
        #2 clrn = 1'b1;

        // No keys: outputs stay clear, rows rotate.
        frames(12'd0, 4);
        // Key 5 held then released.
        frames(key_bit(4), 5);
        frames(12'd0, 4);
        // Key 0, key 9, key 1.
        frames(key_bit(10), 3);
        frames(key_bit(8), 3);
        frames(key_bit(0), 3);
        frames(12'd0, 3);
        // Keys 2 and 7 together (NONE), then 7 released.
        frames(key_bit(1) | key_bit(6), 3);
        frames(key_bit(1), 3);
        frames(12'd0, 3);
        // '*' held, '#' held, then '*' bouncing.
        frames(key_bit(9), 3);
        frames(12'd0, 3);
        frames(key_bit(11), 3);
        frames(12'd0, 3);
        frame(key_bit(9)); frame(12'd0); frame(key_bit(9)); frame(12'd0);
        frame(key_bit(9)); frame(key_bit(9)); frame(key_bit(9));
        // Direct change A -> B.
        frames(key_bit(3), 3);
        frames(key_bit(7), 3);
        frames(12'd0, 3);
        // Key 3 stable, then reset mid-frame, then reacquired.
        frames(key_bit(2), 3);
        mask = key_bit(2);
        repeat (FRAME / 2 + 1) @(negedge clk);
        do_reset(3);
        frames(key_bit(2), 3);
        frames(12'd0, 3);

        // Randomised segments.
        for (int seg = 0; seg < 80; seg++) begin
            kind = $urandom_range(0, 9);
            hold = $urandom_range(1, 4);
            if (kind <= 2)      m = 12'd0;
            else if (kind <= 7) m = key_bit($urandom_range(0, 11));
            else                m = key_bit($urandom_range(0, 11)) | key_bit($urandom_range(0, 11));
            frames(m, hold);
        end
        frames(12'd0, 3);

        @(negedge clk);
        @(negedge clk);
        chk("frame_queue_drained", exp_frame_q.size(), 0);
        chk("pulse_queue_drained", exp_pulse_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x3 active-low key matrix and drives the microwave front end with a debounced one-hot digit vector in the format the keypad encoder consumes. It generates row strobes, samples columns once per row, assembles a full-frame key code, and requires the code to be stable over consecutive frames before updating its outputs. It sits between the panel pins and the encoder. `*` and `#` are reported on separate outputs.

## Interface
- `SCAN_DIV`, 100: clock cycles each row is driven; legal range ≥ 4.
- `DEBOUNCE`, 4: number of consecutive identical frames required before the outputs update; legal range 1–15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `clrn` in 1: asynchronous, active-low reset.
- `col_n` in 3: matrix columns, active low (pulled up). `col_n[0]` is the left column.
- `row_n` out 4: row strobes, active-low one-hot. `row_n[0]` is the top row.
- `keypad` out 10: debounced one-hot digit vector. Key d (1–9) sets bit 10−d; key 0 sets bit 0. All zeros means no digit.
- `key_star` out 1: debounced `*` held.
- `key_hash` out 1: debounced `#` held.
- `key_pressed` out 1: one-cycle pulse when a new non-empty stable code is accepted.

## Operation
Matrix layout (left to right):
- row0: 1, 2, 3
- row1: 4, 5, 6
- row2: 7, 8, 9
- row3: `*`, 0, `#`

Row sequencer:
- A dwell counter runs 0..`SCAN_DIV`−1.
- At the last dwell cycle, the current row's columns are captured into `samp[row]`, then `row_n` rotates to the next row (row3 wraps to row0).
- A frame is 4×`SCAN_DIV` cycles.

Frame code, evaluated at the row3 capture edge using `samp[0..2]` and the live row3 sample:
- Exactly one asserted contact in the frame: that key's code (12 possible values).
- Zero contacts, or two or more contacts (ghosting or multi-press): the code is NONE.

Debounce state machine, with states IDLE and TRACK. Registers: `cand` (a code) and `cnt` (4 bits).
- At each frame end, if code == `cand`: `cnt` increments, saturating at `DEBOUNCE`. Otherwise `cand` = code and `cnt` = 1.
- When `cnt` reaches `DEBOUNCE`, `cand` becomes the stable code.
  - `keypad`, `key_star` and `key_hash` are loaded from the stable code.
  - If the stable code differs from the previous stable code and is not NONE, `key_pressed` pulses.
- IDLE means the stable code is NONE; TRACK means the stable code is a key.
- The return to NONE uses the same debounce, so release also takes `DEBOUNCE` frames.
- A key held indefinitely produces exactly one `key_pressed` pulse (no auto-repeat).
- Changing directly from key A to key B without an intervening NONE outputs B after debounce and pulses `key_pressed`.

## Timing
Reset values (while `clrn` = 0, and held after release until the first edge):
- `row_n` = 4'b1110.
- Dwell counter = 0, `samp` = 0, `cand` = NONE, `cnt` = 0.
- `keypad` = 0, `key_star` = 0, `key_hash` = 0, `key_pressed` = 0.

Reset mid-frame abandons the frame. Scanning restarts at row0, dwell 0.

Output registers update on the same edge as the row3 capture that completes the `DEBOUNCE`-th matching frame.

Latency from a press becoming steady to `keypad` updating: at most (`DEBOUNCE`+1)×4×`SCAN_DIV` cycles and at least (`DEBOUNCE`−1)×4×`SCAN_DIV`+1 cycles.

`key_pressed` is high for exactly one cycle and is coincident with the output update.

## Configuration
`KEYPAD_SYNC_EN`:
- Defined: `col_n` passes through a two-flop synchronizer before sampling, so the captured value reflects `col_n` from 2 cycles earlier (still within the dwell, since `SCAN_DIV` ≥ 4).
- Undefined: `col_n` is sampled directly at the capture edge.

Frame and debounce behaviour are otherwise identical in both builds.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE`=2, and are run in both macro builds.
- Reset, no keys: `row_n` cycles 1110→1101→1011→0111 every 4 cycles; `keypad` stays 0 and `key_pressed` never fires.
- Key 5 held (`col_n[1]` low only while row1 is driven) for 5 frames: `keypad` = 10'b0000100000 within 3 frames, with exactly one `key_pressed` pulse. After release, `keypad` returns to 0 within 3 frames and no pulse occurs.
- Key 0 held: `keypad` = 10'b0000000001. Key 9 held: `keypad` = 10'b0000000010. Key 1 held: `keypad` = 10'b1000000000.
- Keys 2 and 7 held together: the code is NONE and `keypad` stays 0. Releasing 7 leaves 2 held, giving `keypad` = 10'b0100000000 after debounce with one pulse.
- `*` held: `key_star` = 1 and `keypad` = 0. Bounce that toggles 3 alternate frames with 0/press produces no output change until 2 equal consecutive frames occur.
- `clrn` pulsed low mid-frame while key 3 is stable: all outputs are 0 immediately, and `keypad` = 10'b0010000000 is reacquired after debounce with a new pulse.
